// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches, buffers returned
// words with their PCs, and hands them to decode; redirects flush and drop in-flight words.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_except
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic          run_r;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] live_r;
  logic [CW-1:0] discard_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic          except_r;
  logic [31:0]   inst_buf_r [DEPTH];
  logic [31:0]   pc_buf_r   [DEPTH];

  logic [SW-1:0] credit_s;
  logic          req_s;
  logic          grant_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic          consumed_s;
  logic          valid_s;

  logic [31:0]   fetch_pc_n_s;
  logic [31:0]   resp_pc_n_s;
  logic [CW-1:0] count_n_s;
  logic [CW-1:0] live_n_s;
  logic [CW-1:0] discard_n_s;
  logic [PW-1:0] rd_ptr_n_s;
  logic [PW-1:0] wr_ptr_n_s;
  logic          except_n_s;

  // Handshake decode: credit check, grant, response classification and pop.
  always_comb begin
    credit_s   = SW'(count_r) + SW'(live_r) + SW'(discard_r);
    valid_s    = (count_r != {CW{1'b0}});
    req_s      = run_r & ~redirect & ~except_r & (credit_s < DEPTH_S);
    grant_s    = req_s & mem_gnt;
    drop_s     = mem_rvalid & (discard_r != {CW{1'b0}});
    push_s     = mem_rvalid & (discard_r == {CW{1'b0}}) & (live_r != {CW{1'b0}});
    consumed_s = drop_s | push_s;
    pop_s      = valid_s & inst_ready;
  end

  // Next-state computation; a redirect overrides every normal update.
  always_comb begin
    fetch_pc_n_s = fetch_pc_r;
    resp_pc_n_s  = resp_pc_r;
    count_n_s    = count_r;
    live_n_s     = live_r;
    discard_n_s  = discard_r;
    rd_ptr_n_s   = rd_ptr_r;
    wr_ptr_n_s   = wr_ptr_r;
    except_n_s   = except_r;
    if (redirect) begin
      fetch_pc_n_s = redirect_pc;
      resp_pc_n_s  = redirect_pc;
      count_n_s    = {CW{1'b0}};
      rd_ptr_n_s   = {PW{1'b0}};
      wr_ptr_n_s   = {PW{1'b0}};
      live_n_s     = {CW{1'b0}};
      // Whatever is still outstanding after this cycle's response must be dropped.
      discard_n_s  = discard_r + live_r - CW'(consumed_s);
      except_n_s   = (redirect_pc[1:0] != 2'b00);
    end else begin
      if (grant_s) begin
        fetch_pc_n_s = fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_n_s = fetch_pc_r;
      end
      if (push_s) begin
        resp_pc_n_s = resp_pc_r + 32'd4;
        wr_ptr_n_s  = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        resp_pc_n_s = resp_pc_r;
        wr_ptr_n_s  = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_n_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_n_s = rd_ptr_r;
      end
      count_n_s   = count_r + CW'(push_s) - CW'(pop_s);
      live_n_s    = live_r + CW'(grant_s) - CW'(push_s);
      discard_n_s = discard_r - CW'(drop_s);
    end
  end

  // Control state registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_r      <= 1'b0;
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      count_r    <= {CW{1'b0}};
      live_r     <= {CW{1'b0}};
      discard_r  <= {CW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      except_r   <= 1'b0;
    end else begin
      run_r      <= 1'b1;
      fetch_pc_r <= fetch_pc_n_s;
      resp_pc_r  <= resp_pc_n_s;
      count_r    <= count_n_s;
      live_r     <= live_n_s;
      discard_r  <= discard_n_s;
      rd_ptr_r   <= rd_ptr_n_s;
      wr_ptr_r   <= wr_ptr_n_s;
      except_r   <= except_n_s;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !redirect) begin
      inst_buf_r[wr_ptr_r] <= mem_rdata;
      pc_buf_r[wr_ptr_r]   <= resp_pc_r;
    end
  end

  assign mem_req      = req_s;
  assign mem_addr     = fetch_pc_r;
  assign inst_valid   = valid_s;
  assign inst         = inst_buf_r[rd_ptr_r];
  assign inst_pc      = pc_buf_r[rd_ptr_r];
  assign fetch_except = except_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model plus a queue-based
// reference of delivered instructions, checked every cycle.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_except;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fetch_except(fetch_except)
  );

  typedef struct { logic keep; logic [31:0] pc; } fl_t;
  typedef struct { int due; logic [31:0] data; } mr_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  fl_t         infl[$];
  mr_t         memq[$];
  logic [63:0] q[$];
  logic        m_run;
  logic        m_exc;
  logic [31:0] m_pc;

  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          scramble = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc_v = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ (scramble ? 32'h9E37_79B9 : 32'h0000_0000);
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (infl[i]) if (infl[i].keep) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    infl.delete();
    memq.delete();
    q.delete();
    m_run = 1'b0;
    m_exc = 1'b0;
    m_pc  = RESET_PC;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle();
    logic exp_req, exp_valid, grant;
    logic [63:0] e;
    fl_t h;
    int lat;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = memq[0].data;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom();
    end
    mem_gnt     = ($urandom_range(99) < gnt_pct);
    inst_ready  = ($urandom_range(99) < rdy_pct);
    redirect    = redir_v;
    redirect_pc = redir_pc_v;
    #1;
    exp_req   = m_run && !redirect && !m_exc && (q.size() + infl.size() < DEPTH);
    exp_valid = (q.size() > 0);
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("mem_addr", mem_addr, m_pc);
    check("inst_valid", 32'(inst_valid), 32'(exp_valid));
    check("fetch_except", 32'(fetch_except), 32'(m_exc));
    if (exp_valid) begin
      e = q[0];
      check("inst", inst, e[63:32]);
      check("inst_pc", inst_pc, e[31:0]);
    end
    grant = exp_req && mem_gnt;
    if (exp_valid && inst_ready) void'(q.pop_front());
    if (mem_rvalid) begin
      void'(memq.pop_front());
      if (infl.size() > 0) begin
        h = infl.pop_front();
        if (h.keep) q.push_back({mem_rdata, h.pc});
      end
    end
    if (grant) begin
      lat = $urandom_range(lat_max, lat_min);
      infl.push_back('{1'b1, m_pc});
      memq.push_back('{cyc + lat, word_of(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      q.delete();
      foreach (infl[i]) infl[i].keep = 1'b0;
      m_pc  = redirect_pc;
      m_exc = (redirect_pc[1:0] != 2'b00);
    end
    m_run = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redir_v    = 1'b1;
    redir_pc_v = pc;
    cycle();
    redir_v    = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!inst_valid && n < 30) begin
      cycle();
      n++;
    end
    check(name, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    bit found;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0; inst_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0040_0000);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_except", 32'(fetch_except), 32'd0);
    reset = 1'b1;

    // Streaming: word = address, 1-cycle memory, always ready.
    repeat (3) cycle();
    check("first_valid", 32'(inst_valid), 32'd1);
    check("first_pc", inst_pc, 32'h0040_0000);
    check("first_inst", inst, 32'h0040_0000);
    repeat (20) cycle();
    check("stream_pc", inst_pc, 32'h0040_0050);

    // Reset mid-stream with the queue half full.
    rdy_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 2) begin found = 1'b1; break; end
      cycle();
    end
    check("half_full_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_inst_valid", 32'(inst_valid), 32'd0);
    check("arst_mem_addr", mem_addr, 32'h0040_0000);
    model_reset();
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Backpressure from restart: queue fills, requests stop after 4 grants.
    repeat (12) cycle();
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_head", inst_pc, 32'h0040_0000);
    check("bp_addr", mem_addr, 32'h0040_0010);
    check("bp_no_req", 32'(mem_req), 32'd0);
    rdy_pct = 100;
    repeat (30) cycle();

    // Redirect with three live in-flight fetches on a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (live_cnt() == 3) begin found = 1'b1; break; end
      cycle();
    end
    check("live3_reached", 32'(found), 32'd1);
    do_redirect(32'h0040_0100);
    check("redir_flush", 32'(inst_valid), 32'd0);
    wait_valid("redir_valid");
    check("redir_pc", inst_pc, 32'h0040_0100);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 2; gnt_pct = 70;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && q.size() > 0) begin found = 1'b1; break; end
      cycle();
    end
    check("simul_found", 32'(found), 32'd1);
    do_redirect(32'h0040_0300);
    check("simul_empty", 32'(inst_valid), 32'd0);
    wait_valid("simul_valid");
    check("simul_pc", inst_pc, 32'h0040_0300);

    // Misaligned redirect: sticky exception, no requests, then recovery.
    gnt_pct = 100;
    do_redirect(32'h0040_0102);
    check("mis_except", 32'(fetch_except), 32'd1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("mis_no_req", 32'(mem_req), 32'd0);
    end
    do_redirect(32'h0040_0200);
    check("mis_cleared", 32'(fetch_except), 32'd0);
    wait_valid("mis_valid");
    check("mis_resume_pc", inst_pc, 32'h0040_0200);

    // Randomized traffic with occasional redirects, some misaligned.
    scramble = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        gnt_pct = $urandom_range(100, 20);
        rdy_pct = $urandom_range(100, 20);
        lat_min = $urandom_range(2, 1);
        lat_max = lat_min + $urandom_range(3);
      end
      if ($urandom_range(99) < 3) begin
        redir_v    = 1'b1;
        redir_pc_v = 32'h0040_0000 + (32'($urandom_range(255)) << 2)
                   + (($urandom_range(99) < 20) ? 32'($urandom_range(3, 1)) : 32'd0);
      end else begin
        redir_v = 1'b0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue that sits directly upstream of the core's decode/execute stage. Issues in-order word fetches to an instruction memory with a variable-latency request/response handshake. Buffers up to DEPTH returned instructions with their PCs, and hands them to the core with a valid/ready handshake. Supports branch/jump redirect with flush and discard of in-flight responses, and flags misaligned redirect targets.

## Interface
- DEPTH, 4: queue entries; also the cap on (queued + in-flight) fetches. Power of two, 2..16.
- RESET_PC, 32'h00400000: first fetch address after reset.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- redirect  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address, byte address.
- mem_req  out  1  fetch request valid.
- mem_addr  out  32  fetch byte address; equals fetch_pc.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  response valid; responses return strictly in request order.
- mem_rdata  in  32  response instruction word.
- inst_valid  out  1  queue head valid.
- inst  out  32  head instruction.
- inst_pc  out  32  PC of the head instruction.
- inst_ready  in  1  core consumes the head this cycle.
- fetch_except  out  1  misaligned redirect target; sticky.

## Operation
- **State:**
  - run flag
  - fetch_pc
  - resp_pc (PC of the next live response)
  - count (0..DEPTH)
  - live (in-flight, to be kept)
  - discard (in-flight, to be dropped)
  - circular buffer of {inst, pc} with rd/wr pointers
  - fetch_except
- **Reset values:**
  - run=0, fetch_pc=resp_pc=RESET_PC, count=live=discard=0, pointers 0, fetch_except=0.
  - Resulting outputs: mem_req=0, mem_addr=RESET_PC, inst_valid=0, fetch_except=0; inst/inst_pc are don't-care while inst_valid=0.
- **run:** set at the first posedge with reset=1; never cleared except by reset.
- **Request:** mem_req = run & !redirect & !fetch_except & (count+live+discard < DEPTH).
  - Grant = mem_req & mem_gnt.
  - On grant: fetch_pc += 4 (32-bit wrap); live += 1.
- **Response:** on mem_rvalid:
  - If discard>0: word dropped, discard -= 1.
  - Else if live>0: push {mem_rdata, resp_pc}, resp_pc += 4, live -= 1.
  - If live=discard=0: ignore the response (stray after reset).
- **Pop:** when inst_valid & inst_ready, advance rd pointer.
  - Push and pop in the same cycle leaves count unchanged.
  - The credit rule guarantees a push never finds the queue full.
- **Redirect (posedge with redirect=1):**
  - count cleared; pointers reset.
  - discard <= discard + live − (response consumed this cycle); live <= 0.
  - fetch_pc <= resp_pc <= redirect_pc.
  - A pop requested in the same cycle is accepted but irrelevant; the queue is emptied.
  - fetch_except <= (redirect_pc[1:0] != 0).
- **fetch_except=1:**
  - No requests are issued; in-flight responses still drain via discard.
  - Cleared only by a redirect to an aligned address, or by reset.

## Timing
- Grant at posedge N → earliest mem_rvalid in cycle N+1.
- Response captured at posedge M → inst_valid=1 in cycle M+1. There is no combinational bypass from mem_rdata to inst.
- Steady state with 1-cycle memory and inst_ready=1: one instruction per cycle after a 3-cycle startup.
  - Cycle 1 after reset release: mem_req rises.
  - Cycle 2: first response.
  - Cycle 3: first inst_valid.
- Redirect in cycle R:
  - inst_valid=0 in R+1.
  - First new request in R+1.
  - First new instruction no earlier than R+3.
- Full (count+live+discard=DEPTH): mem_req=0 in that cycle. It reasserts the cycle after a pop or a dropped response frees a slot.
- Reset asserted mid-operation: all outputs take their reset values asynchronously. The memory side is reset by the same signal.

## Test plan
- **Reset and streaming:**
  - Stimulus: release reset; 1-cycle memory returning word = address; inst_ready=1.
  - Required: inst_pc sequence 0x00400000, 0x00400004, … with inst = inst_pc, one per cycle from cycle 3.
- **Backpressure:**
  - Stimulus: inst_ready=0 for 10 cycles.
  - Required:
    - count reaches 4.
    - mem_req=0 after 4 grants.
    - Head holds 0x00400000.
    - On release, 4 queued then continued stream, no gaps or duplicates.
- **Redirect with in-flight responses:**
  - Stimulus: 3-cycle memory latency; redirect to 0x00400100 with live=3.
  - Required:
    - The 3 stale words are dropped (discard 3→0).
    - First delivered inst_pc = 0x00400100.
- **Simultaneous events:**
  - Stimulus: redirect in the same cycle as mem_rvalid and a pop.
  - Required: the arriving response is counted off live; the queue is empty next cycle; no stale PC is ever delivered.
- **Misaligned redirect:**
  - Stimulus: redirect_pc=0x00400102.
  - Required:
    - fetch_except=1 next cycle.
    - mem_req stays 0 for 20 cycles.
    - A later redirect to 0x00400200 clears the flag and fetch resumes there.
- **Reset mid-stream:**
  - Stimulus: assert reset between clock edges with queue half full.
  - Required:
    - inst_valid and mem_req drop immediately.
    - After release, fetch restarts at 0x00400000.
